// File: rtl/img_mem_reader_if.sv
// Handshake bundle for img_mem_reader: address stream in, RAM read port, pixel stream out.
// The slave modport is the reader's view; the master modport is the surrounding system's view.
interface img_mem_reader_if #(
  parameter int W_ADDR = 12,
  parameter int W_DATA = 8
);
  logic              addr_valid;
  logic              addr_ready;
  logic [W_ADDR-1:0] addr;
  logic              mem_rd_en;
  logic [W_ADDR-1:0] mem_rd_addr;
  logic [W_DATA-1:0] mem_rd_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [W_DATA-1:0] dout_data;

  modport slave (
    input  addr_valid, addr, mem_rd_data, dout_ready,
    output addr_ready, mem_rd_en, mem_rd_addr, dout_valid, dout_data
  );

  modport master (
    output addr_valid, addr, mem_rd_data, dout_ready,
    input  addr_ready, mem_rd_en, mem_rd_addr, dout_valid, dout_data
  );
endinterface

// File: rtl/img_mem_reader.sv
// Read adapter from a pixel address stream to a fixed-latency image RAM, with a credit-guarded
// return FIFO so downstream backpressure never has to stall the RAM.
module img_mem_reader #(
  parameter int W_DATA     = 8,
  parameter int IMG_WIDTH  = 41,
  parameter int IMG_HEIGHT = 50,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  img_mem_reader_if.slave     bus,
  output logic                err_oob
);
  localparam int N_PIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int W_ADDR = $clog2(N_PIX);
  localparam int W_CNT  = $clog2(FIFO_DEPTH + 1);
  localparam int W_PTR  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  generate
    if (RD_LATENCY < 1) begin : g_lat_check
      $error("img_mem_reader: RD_LATENCY must be >= 1");
    end
    if (FIFO_DEPTH < RD_LATENCY + 2) begin : g_depth_check
      $error("img_mem_reader: FIFO_DEPTH must be >= RD_LATENCY+2");
    end
  endgenerate

  function automatic logic [W_PTR-1:0] next_ptr(input logic [W_PTR-1:0] p);
    return (p == W_PTR'(FIFO_DEPTH - 1)) ? '0 : p + W_PTR'(1);
  endfunction

  logic                  acc;
  logic                  in_range;
  logic                  wr;
  logic                  pop;
  logic [W_DATA-1:0]     wr_data;
  logic [RD_LATENCY-1:0] vld_p, vld_nxt;
  logic [RD_LATENCY-1:0] oob_p, oob_nxt;
  logic [W_CNT-1:0]      inflight;
  logic [W_CNT-1:0]      count;
  logic [W_CNT:0]        credit_used;
  logic [W_PTR-1:0]      wr_ptr;
  logic [W_PTR-1:0]      rd_ptr;
  logic [W_ADDR-1:0]     last_addr;
  logic [W_DATA-1:0]     fifo_mem [FIFO_DEPTH];

  // Accept stage: credits come from registers only, so addr_ready never sees dout_ready
  assign credit_used    = {1'b0, inflight} + {1'b0, count};
  assign bus.addr_ready = credit_used < (W_CNT + 1)'(FIFO_DEPTH);
  assign in_range       = {1'b0, bus.addr} < (W_ADDR + 1)'(N_PIX);
  assign acc            = bus.addr_valid & bus.addr_ready;
  assign bus.mem_rd_en  = acc & in_range;
  assign bus.mem_rd_addr = bus.addr_valid ? bus.addr : last_addr;

  always_comb begin
    vld_nxt    = vld_p << 1;
    oob_nxt    = oob_p << 1;
    vld_nxt[0] = acc;
    oob_nxt[0] = acc & ~in_range;
  end

  // Return stage: the slot leaving the pipe lines up with the RAM data for that request
  assign wr      = vld_p[RD_LATENCY-1];
  assign wr_data = oob_p[RD_LATENCY-1] ? '0 : bus.mem_rd_data;

  // Output stage: data is gated so an empty FIFO always presents zero
  assign bus.dout_valid = (count != '0);
  assign bus.dout_data  = bus.dout_valid ? fifo_mem[rd_ptr] : '0;
  assign pop            = bus.dout_valid & bus.dout_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p     <= '0;
      oob_p     <= '0;
      inflight  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_addr <= '0;
      err_oob   <= 1'b0;
    end else begin
      vld_p <= vld_nxt;
      oob_p <= oob_nxt;
      if (acc && !wr) begin
        inflight <= inflight + W_CNT'(1);
      end else if (wr && !acc) begin
        inflight <= inflight - W_CNT'(1);
      end
      if (wr && !pop) begin
        count <= count + W_CNT'(1);
      end else if (pop && !wr) begin
        count <= count - W_CNT'(1);
      end
      if (wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (bus.addr_valid) begin
        last_addr <= bus.addr;
      end
      if (acc && !in_range) begin
        err_oob <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      fifo_mem[wr_ptr] <= wr_data;
    end
  end

  wr_never_full: assert property (@(posedge clk) disable iff (!rst)
    !(wr && (count == W_CNT'(FIFO_DEPTH))));

endmodule
